// File: rtl/sdram_client_arbiter.sv
// rtl/sdram_client_arbiter.sv - two-client toggle-handshake arbiter in front of an SDRAM command backend
module sdram_client_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic [26:1] cpu_addr,
   input  logic [15:0] cpu_data,
   input  logic [1:0]  cpu_be,
   input  logic        cpu_rw,
   input  logic        cpu_req,
   output logic        cpu_ack,
   output logic [15:0] cpu_q,
   input  logic [26:1] scn_addr,
   input  logic        scn_req,
   output logic        scn_ack,
   output logic [31:0] scn_q,
   output logic [26:1] mem_addr,
   output logic [15:0] mem_wdata,
   output logic [1:0]  mem_be,
   output logic        mem_we,
   output logic        mem_cmd_valid,
   input  logic        mem_cmd_ready,
   input  logic        mem_rd_valid,
   input  logic [15:0] mem_rd_data
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CPU_CMD  = 3'd1,
      CPU_RD   = 3'd2,
      SCN_CMD0 = 3'd3,
      SCN_RD0  = 3'd4,
      SCN_CMD1 = 3'd5,
      SCN_RD1  = 3'd6
   } state_t;

   state_t state, state_next;

   logic cpu_pend;
   logic scn_pend;
   logic last_scn;     // 1 when scn was the most recent grant
   logic grant_cpu;
   logic grant_scn;
   logic cmd_accept;

   // A client is pending while its request toggle differs from our acknowledge toggle.
   assign cpu_pend   = cpu_req ^ cpu_ack;
   assign scn_pend   = scn_req ^ scn_ack;
   assign cmd_accept = mem_cmd_valid & mem_cmd_ready;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next state and grant decisions; ties go to the client not granted last.
   always_comb begin
      state_next = state;
      grant_cpu  = 1'b0;
      grant_scn  = 1'b0;
      case (state)
         IDLE: begin
            if (cpu_pend && (!scn_pend || last_scn)) begin
               grant_cpu  = 1'b1;
               state_next = CPU_CMD;
            end else if (scn_pend) begin
               grant_scn  = 1'b1;
               state_next = SCN_CMD0;
            end
         end
         CPU_CMD:  if (cmd_accept)   state_next = mem_we ? IDLE : CPU_RD;
         CPU_RD:   if (mem_rd_valid) state_next = IDLE;
         SCN_CMD0: if (cmd_accept)   state_next = SCN_RD0;
         SCN_RD0:  if (mem_rd_valid) state_next = SCN_CMD1;
         SCN_CMD1: if (cmd_accept)   state_next = SCN_RD1;
         SCN_RD1:  if (mem_rd_valid) state_next = IDLE;
         default:                    state_next = IDLE;
      endcase
   end

   // Command fields, read-data capture, acknowledge toggles and grant history.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cpu_ack       <= 1'b0;
         scn_ack       <= 1'b0;
         cpu_q         <= 16'h0000;
         scn_q         <= 32'h0000_0000;
         mem_addr      <= '0;
         mem_wdata     <= 16'h0000;
         mem_be        <= 2'b00;
         mem_we        <= 1'b0;
         mem_cmd_valid <= 1'b0;
         last_scn      <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (grant_cpu) begin
                  mem_addr      <= cpu_addr;
                  mem_wdata     <= cpu_data;
                  mem_be        <= cpu_be;
                  mem_we        <= ~cpu_rw;
                  mem_cmd_valid <= 1'b1;
                  last_scn      <= 1'b0;
               end else if (grant_scn) begin
                  mem_addr      <= scn_addr;
                  mem_be        <= 2'b11;
                  mem_we        <= 1'b0;
                  mem_cmd_valid <= 1'b1;
                  last_scn      <= 1'b1;
               end
            end
            CPU_CMD: begin
               if (cmd_accept) begin
                  mem_cmd_valid <= 1'b0;
                  // Writes complete at acceptance; reads wait for their data.
                  if (mem_we) cpu_ack <= ~cpu_ack;
               end
            end
            CPU_RD: begin
               if (mem_rd_valid) begin
                  cpu_q   <= mem_rd_data;
                  cpu_ack <= ~cpu_ack;
               end
            end
            SCN_CMD0, SCN_CMD1: begin
               if (cmd_accept) mem_cmd_valid <= 1'b0;
            end
            SCN_RD0: begin
               if (mem_rd_valid) begin
                  scn_q[31:16]  <= mem_rd_data;
                  // Second half of the tilemap word; 26-bit increment wraps naturally.
                  mem_addr      <= mem_addr + 26'd1;
                  mem_cmd_valid <= 1'b1;
               end
            end
            SCN_RD1: begin
               if (mem_rd_valid) begin
                  scn_q[15:0] <= mem_rd_data;
                  scn_ack     <= ~scn_ack;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_client_arbiter.sv
// tb/tb_sdram_client_arbiter.sv - randomized self-checking bench for sdram_client_arbiter
module tb_sdram_client_arbiter;

   logic        clk;
   logic        reset;
   logic [26:1] cpu_addr;
   logic [15:0] cpu_data;
   logic [1:0]  cpu_be;
   logic        cpu_rw;
   logic        cpu_req;
   logic        cpu_ack;
   logic [15:0] cpu_q;
   logic [26:1] scn_addr;
   logic        scn_req;
   logic        scn_ack;
   logic [31:0] scn_q;
   logic [26:1] mem_addr;
   logic [15:0] mem_wdata;
   logic [1:0]  mem_be;
   logic        mem_we;
   logic        mem_cmd_valid;
   logic        mem_cmd_ready;
   logic        mem_rd_valid;
   logic [15:0] mem_rd_data;

   sdram_client_arbiter dut (
      .clk(clk), .reset(reset),
      .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_be(cpu_be), .cpu_rw(cpu_rw),
      .cpu_req(cpu_req), .cpu_ack(cpu_ack), .cpu_q(cpu_q),
      .scn_addr(scn_addr), .scn_req(scn_req), .scn_ack(scn_ack), .scn_q(scn_q),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_we(mem_we),
      .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
      .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Memory contents: backend view (bmem) and the bench's golden view (gmem).
   logic [15:0] bmem [logic [26:1]];
   logic [15:0] gmem [logic [26:1]];

   function automatic logic [15:0] init_word(input logic [26:1] a);
      return a[16:1] ^ {a[26:17], a[6:1]} ^ 16'h5A3C;
   endfunction

   function automatic logic [15:0] merge_be(input logic [15:0] old, input logic [15:0] nw, input logic [1:0] be);
      return {be[1] ? nw[15:8] : old[15:8], be[0] ? nw[7:0] : old[7:0]};
   endfunction

   function automatic logic [15:0] bread(input logic [26:1] a);
      return bmem.exists(a) ? bmem[a] : init_word(a);
   endfunction

   function automatic logic [15:0] gread(input logic [26:1] a);
      return gmem.exists(a) ? gmem[a] : init_word(a);
   endfunction

   // Backend model controls and logs.
   int          tick = 0;
   int          n_accept = 0;
   int          hold_off = 0;
   bit          rand_ready = 0;
   int          rd_lat_max = 1;
   bit          hold_rd = 0;
   bit          stray = 0;
   int          rd_due[$];
   logic [15:0] rd_dat[$];
   logic [44:0] cmd_log[$];   // {we, be, addr, wdata}
   bit          prev_pend = 0;
   logic [45:0] prev_fields;

   // Backend: acts just after each falling edge so bench-driven settings are already visible.
   initial begin
      mem_cmd_ready = 1'b1;
      mem_rd_valid  = 1'b0;
      mem_rd_data   = 16'h0000;
      forever begin
         @(negedge clk);
         #1;
         tick++;
         mem_rd_valid = 1'b0;
         if (reset) prev_pend = 0;
         if (stray) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = 16'hDEAD;
            stray        = 0;
         end else if (!hold_rd && rd_due.size() > 0 && rd_due[0] <= tick) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = rd_dat.pop_front();
            void'(rd_due.pop_front());
         end
         if (prev_pend)
            check_eq("cmd_hold", {mem_cmd_valid, mem_we, mem_be, mem_addr, mem_wdata}, prev_fields);
         prev_pend = 0;
         if (hold_off > 0) begin
            mem_cmd_ready = 1'b0;
            hold_off--;
         end else if (rand_ready) begin
            mem_cmd_ready = 1'($urandom_range(0, 1));
         end else begin
            mem_cmd_ready = 1'b1;
         end
         if (!reset && mem_cmd_valid) begin
            if (mem_cmd_ready) begin
               n_accept++;
               cmd_log.push_back({mem_we, mem_be, mem_addr, mem_wdata});
               if (mem_we) begin
                  bmem[mem_addr] = merge_be(bread(mem_addr), mem_wdata, mem_be);
               end else begin
                  rd_due.push_back(tick + $urandom_range(1, rd_lat_max));
                  rd_dat.push_back(bread(mem_addr));
               end
            end else begin
               prev_pend   = 1;
               prev_fields = {mem_cmd_valid, mem_we, mem_be, mem_addr, mem_wdata};
            end
         end
      end
   end

   // Reference model state.
   bit          model_last_cpu = 0;
   logic [15:0] model_cpu_q = 16'h0000;
   logic [31:0] model_scn_q = 32'h0;

   task automatic do_reset();
      reset   = 1'b1;
      cpu_req = 1'b0;
      scn_req = 1'b0;
      repeat (2) @(negedge clk);
      rd_due.delete();
      rd_dat.delete();
      hold_off       = 0;
      reset          = 1'b0;
      model_last_cpu = 0;
      model_cpu_q    = 16'h0000;
      model_scn_q    = 32'h0;
   endtask

   task automatic wait_acks(input bit wc, input bit ws, output int tc, output int ts);
      logic c0, s0;
      int   t;
      c0 = cpu_ack; s0 = scn_ack;
      tc = -1; ts = -1; t = 0;
      while (((wc && tc < 0) || (ws && ts < 0)) && t < 300) begin
         @(negedge clk);
         t++;
         if (wc && tc < 0 && cpu_ack != c0) tc = t;
         if (ws && ts < 0 && scn_ack != s0) ts = t;
      end
      if (wc && tc < 0) check_eq("cpu_ack_timeout", cpu_ack, ~c0);
      if (ws && ts < 0) check_eq("scn_ack_timeout", scn_ack, ~s0);
   endtask

   task automatic model_cpu(input logic [26:1] ca, input logic [15:0] cd, input logic [1:0] cb, input logic cr);
      if (cr) model_cpu_q = gread(ca);
      else    gmem[ca] = merge_be(gread(ca), cd, cb);
   endtask

   task automatic model_scn(input logic [26:1] sa);
      logic [26:1] sa1;
      sa1 = sa + 26'd1;
      model_scn_q = {gread(sa), gread(sa1)};
   endtask

   // Issue one or both requests in the same cycle, wait for completion, check against the model.
   task automatic run_txn(input bit wc, input bit ws, input logic [26:1] ca, input logic [15:0] cd,
                          input logic [1:0] cb, input logic cr, input logic [26:1] sa,
                          output int tc, output int ts);
      bit first_cpu;
      if (wc) begin
         cpu_addr = ca; cpu_data = cd; cpu_be = cb; cpu_rw = cr;
         cpu_req  = ~cpu_req;
      end
      if (ws) begin
         scn_addr = sa;
         scn_req  = ~scn_req;
      end
      wait_acks(wc, ws, tc, ts);
      first_cpu = (wc && ws) ? !model_last_cpu : wc;
      if (wc && ws) check_eq("grant_order_cpu_first", (tc < ts), first_cpu);
      if (first_cpu) begin
         model_cpu(ca, cd, cb, cr);
         if (ws) model_scn(sa);
      end else begin
         model_scn(sa);
         if (wc) model_cpu(ca, cd, cb, cr);
      end
      model_last_cpu = (wc && ws) ? !first_cpu : wc;
      if (wc) check_eq("cpu_q", cpu_q, model_cpu_q);
      if (ws) check_eq("scn_q", scn_q, model_scn_q);
      check_eq("cpu_ack_matches_req", cpu_ack, cpu_req);
      check_eq("scn_ack_matches_req", scn_ack, scn_req);
   endtask

   initial begin
      int          tc, ts, n0, mode, t;
      bit          wc, ws;
      logic [44:0] e0, e1;

      reset = 1'b1;
      cpu_addr = '0; cpu_data = 16'h0; cpu_be = 2'b00; cpu_rw = 1'b0; cpu_req = 1'b0;
      scn_addr = '0; scn_req = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_cpu_ack", cpu_ack, 0);
      check_eq("rst_scn_ack", scn_ack, 0);
      check_eq("rst_cpu_q", cpu_q, 0);
      check_eq("rst_scn_q", scn_q, 0);
      check_eq("rst_cmd_valid", mem_cmd_valid, 0);
      check_eq("rst_mem_we", mem_we, 0);
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_mem_wdata", mem_wdata, 0);
      check_eq("rst_mem_be", mem_be, 0);
      reset = 1'b0;
      @(negedge clk);

      // CPU write, minimum latency.
      n0 = n_accept;
      run_txn(1, 0, 26'h0100000, 16'hBEEF, 2'b01, 1'b0, '0, tc, ts);
      check_eq("wr_latency", tc, 2);
      check_eq("wr_accept_count", n_accept - n0, 1);
      check_eq("wr_cmd", cmd_log[$], {1'b1, 2'b01, 26'h0100000, 16'hBEEF});
      check_eq("wr_cpu_q_zero", cpu_q, 16'h0000);

      // SCN read with known backend data.
      bmem[26'h0012340] = 16'h1111; gmem[26'h0012340] = 16'h1111;
      bmem[26'h0012341] = 16'h2222; gmem[26'h0012341] = 16'h2222;
      run_txn(0, 1, '0, 16'h0, 2'b00, 1'b0, 26'h0012340, tc, ts);
      check_eq("scn_latency", ts, 5);
      check_eq("scn_q_value", scn_q, 32'h1111_2222);
      e0 = cmd_log[cmd_log.size() - 2];
      e1 = cmd_log[cmd_log.size() - 1];
      check_eq("scn_cmd0", e0[44:16], {1'b0, 2'b11, 26'h0012340});
      check_eq("scn_cmd1", e1[44:16], {1'b0, 2'b11, 26'h0012341});

      // CPU read back of the partially written word.
      run_txn(1, 0, 26'h0100000, 16'h0, 2'b00, 1'b1, '0, tc, ts);
      check_eq("rd_latency", tc, 3);
      check_eq("rd_merged_value", cpu_q, {init_word(26'h0100000) >> 8, 8'hEF} & 16'hFFFF);

      // Simultaneous requests right after reset: cpu first, twice.
      do_reset();
      run_txn(1, 1, 26'h0100001, 16'h0, 2'b00, 1'b1, 26'h0012340, tc, ts);
      check_eq("tie1_cpu_first", (tc < ts), 1);
      run_txn(1, 1, 26'h0100000, 16'h0, 2'b00, 1'b1, 26'h0012341, tc, ts);
      check_eq("tie2_cpu_first", (tc < ts), 1);

      // Backpressure: ready low for ten cycles starting with the request cycle.
      n0 = n_accept;
      hold_off = 10;
      run_txn(1, 0, 26'h0100002, 16'h1234, 2'b11, 1'b0, '0, tc, ts);
      check_eq("bp_latency", tc, 11);
      check_eq("bp_accept_count", n_accept - n0, 1);
      repeat (5) @(negedge clk);
      check_eq("bp_single_ack", cpu_ack, cpu_req);

      // Address wrap on the second scn command.
      run_txn(0, 1, '0, 16'h0, 2'b00, 1'b0, 26'h3FFFFFF, tc, ts);
      e0 = cmd_log[cmd_log.size() - 2];
      e1 = cmd_log[cmd_log.size() - 1];
      check_eq("wrap_cmd0", e0[41:16], 26'h3FFFFFF);
      check_eq("wrap_cmd1", e1[41:16], 26'h0000000);

      // Reset while waiting for the first scn read, then a stray read strobe.
      hold_rd  = 1;
      n0       = n_accept;
      scn_addr = 26'h0012340;
      scn_req  = ~scn_req;
      t = 0;
      while (n_accept == n0 && t < 50) begin
         @(negedge clk);
         #2;
         t++;
      end
      check_eq("abort_cmd_accepted", n_accept - n0, 1);
      @(negedge clk);
      do_reset();
      hold_rd = 0;
      stray   = 1;
      repeat (5) @(negedge clk);
      check_eq("abort_scn_ack", scn_ack, 0);
      check_eq("abort_cpu_ack", cpu_ack, 0);
      check_eq("abort_scn_q", scn_q, 0);
      check_eq("abort_idle_no_cmd", mem_cmd_valid, 0);
      run_txn(1, 0, 26'h0100002, 16'h0, 2'b00, 1'b1, '0, tc, ts);
      check_eq("abort_next_rd_latency", tc, 3);

      // Randomized traffic with random backpressure and read latency.
      for (int it = 0; it < 40; it++) begin
         rand_ready = ($urandom_range(0, 1) == 1);
         rd_lat_max = $urandom_range(1, 3);
         mode = $urandom_range(0, 2);
         wc = (mode != 1);
         ws = (mode != 0);
         run_txn(wc, ws, 26'h0200000 + 26'($urandom_range(0, 7)), 16'($urandom), 2'($urandom),
                 1'($urandom), 26'h0200000 + 26'($urandom_range(0, 7)), tc, ts);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sdram_client_arbiter.md
SDRAM_CLIENT_ARBITER -- requirements
Module: sdram_client_arbiter

Interface
REQ-001 clk  in  1  system clock; all logic on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-003 cpu_addr  in  26 [26:1]  CPU word address.
REQ-004 cpu_data  in  16  CPU write data.
REQ-005 cpu_be  in  2  byte enables, [1] upper byte, [0] lower byte.
REQ-006 cpu_rw  in  1  1 = read, 0 = write.
REQ-007 cpu_req  in  1  toggle request; pending while cpu_req != cpu_ack.
REQ-008 cpu_ack  out  1  toggle acknowledge.
REQ-009 cpu_q  out  16  CPU read data.
REQ-010 scn_addr  in  26 [26:1]  tilemap ROM word address, read-only client.
REQ-011 scn_req  in  1  toggle request; pending while scn_req != scn_ack.
REQ-012 scn_ack  out  1  toggle acknowledge.
REQ-013 scn_q  out  32  tilemap ROM read data.
REQ-014 mem_addr  out  26 [26:1]  backend command word address.
REQ-015 mem_wdata  out  16  backend write data.
REQ-016 mem_be  out  2  backend byte enables.
REQ-017 mem_we  out  1  1 = write command.
REQ-018 mem_cmd_valid  out  1  command valid.
REQ-019 mem_cmd_ready  in  1  backend accepts the command when valid and ready are both 1.
REQ-020 mem_rd_valid  in  1  one-cycle read-data strobe; read commands return in order.
REQ-021 mem_rd_data  in  16  read data, qualified by mem_rd_valid.

Function
REQ-022 Clients hold their address, data, be and rw stable from the req toggle until the matching ack toggle; the block samples these inputs when it grants the client.
REQ-023 The FSM has the states IDLE, CPU_CMD, CPU_RD, SCN_CMD0, SCN_RD0, SCN_CMD1 and SCN_RD1.
REQ-024 In IDLE, when only one client is pending, that client is granted.
REQ-025 In IDLE, when both clients are pending, the client that was not granted last is granted; after reset, scn is treated as last-granted, so cpu wins the first tie.
REQ-026 On a cpu grant, the FSM goes to CPU_CMD, with mem_addr=cpu_addr, mem_wdata=cpu_data, mem_be=cpu_be, mem_we=~cpu_rw and mem_cmd_valid=1.
REQ-027 On a scn grant, the FSM goes to SCN_CMD0, with mem_addr=scn_addr, mem_be=2'b11, mem_we=0 and mem_cmd_valid=1.
REQ-028 mem_cmd_valid and the command fields stay stable until the command is accepted (mem_cmd_valid and mem_cmd_ready both 1); mem_cmd_valid is 0 in the cycle after acceptance unless the next command is issued in that cycle.
REQ-029 CPU_CMD, write accepted: cpu_ack toggles in the next cycle and the FSM returns to IDLE; cpu_q is unchanged.
REQ-030 CPU_CMD, read accepted: the FSM goes to CPU_RD; on mem_rd_valid, cpu_q<=mem_rd_data, cpu_ack toggles in the same edge, and the FSM goes to IDLE.
REQ-031 SCN_CMD0 accepted: the FSM goes to SCN_RD0.
REQ-032 In SCN_RD0, on mem_rd_valid, scn_q[31:16]<=mem_rd_data and the FSM goes to SCN_CMD1 with mem_addr=scn_addr+1.
REQ-033 The scn_addr+1 increment is 26-bit and wraps from all-ones to zero.
REQ-034 SCN_CMD1 accepted: the FSM goes to SCN_RD1.
REQ-035 In SCN_RD1, on mem_rd_valid, scn_q[15:0]<=mem_rd_data, scn_ack toggles in the same edge, and the FSM goes to IDLE.
REQ-036 scn_q[31:16] and scn_q[15:0] update only in their own read states; scn_q is fully valid when scn_ack toggles.
REQ-037 mem_rd_valid is ignored in every state except CPU_RD, SCN_RD0 and SCN_RD1.
REQ-038 Only one transaction is outstanding at a time; a new grant occurs only in IDLE.
REQ-039 Minimum service latency, from a req toggle seen in IDLE to the ack toggle, with mem_cmd_ready=1 and read data one cycle after acceptance: cpu write 2 cycles, cpu read 3 cycles, scn read 5 cycles.
REQ-040 A req toggle arriving while the same client is already in service is not lost; it is seen as pending in IDLE after the ack.

Reset
REQ-041 Reset values: state=IDLE, cpu_ack=0, scn_ack=0, cpu_q=0, scn_q=0, mem_cmd_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, last-granted=scn.
REQ-042 Reset mid-transaction abandons the transaction with no ack toggle.
REQ-043 A mem_rd_valid arriving after reset and belonging to the abandoned read is ignored, per REQ-037.

Verification
REQ-044 CPU write: cpu_addr=0x0100000, cpu_data=0xBEEF, be=2'b01, rw=0, toggle cpu_req, ready=1 -> one command with we=1 and be=01, cpu_ack toggles 2 cycles later, cpu_q stays 0.
REQ-045 SCN read: scn_addr=0x0012340; backend returns 0x1111 then 0x2222 -> commands to 0x0012340 then 0x0012341, scn_q=0x11112222 at the scn_ack toggle.
REQ-046 Simultaneous: both clients toggle req in the same cycle after reset -> cpu is served first, then scn; a repeat of both toggles serves cpu again only after scn has been served.
REQ-047 Backpressure: mem_cmd_ready=0 for 10 cycles -> mem_cmd_valid and all command fields are held constant; there is exactly one acceptance and one ack toggle.
REQ-048 Wrap: scn_addr=0x3FFFFFF -> the second command goes to 0x0000000.
REQ-049 Reset during SCN_RD0, then a stray mem_rd_valid -> no ack toggles, scn_q stays 0, the FSM stays IDLE, and the next cpu request completes normally.
